// File: rtl/bs_burst_drainer.sv
// Drains same-row request bursts from NUM_Q queues onto a registered valid/ready stream.
// Define BS_AGING_EN to add per-queue starvation counters that preempt row-hit priority.
module bs_burst_drainer #(
    parameter int NUM_Q      = 4,
    parameter int ENTRY_SIZE = 32,
    parameter int ROW_BITS   = 4,
    parameter int BURST_MAX  = 4,
    parameter int AGE_LIMIT  = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_Q-1:0]            q_empty,
    input  logic [NUM_Q*ROW_BITS-1:0]   q_row,
    input  logic [NUM_Q*ENTRY_SIZE-1:0] q_data,
    output logic [NUM_Q-1:0]            q_rd_en,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ENTRY_SIZE-1:0]       out_data,
    output logic [$clog2(NUM_Q)-1:0]    out_qid,
    output logic [ROW_BITS-1:0]         open_row,
    output logic                        busy
);
    localparam int QW = $clog2(NUM_Q);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [BW-1:0] BMAX = BW'(BURST_MAX);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                r_state, w_state_nxt;
    logic [QW-1:0]         r_gnt, r_rr_last, r_out_qid;
    logic [BW-1:0]         r_burst_cnt;
    logic                  r_open_row_vld, r_out_valid;
    logic [ROW_BITS-1:0]   r_open_row;
    logic [ENTRY_SIZE-1:0] r_out_data;

    logic [ROW_BITS-1:0]   w_row  [NUM_Q];
    logic [ENTRY_SIZE-1:0] w_data [NUM_Q];
    logic [NUM_Q-1:0]      w_cand, w_hit, w_aged;
    logic                  w_hit_found, w_any_found, w_aged_found;
    logic [QW-1:0]         w_hit_idx, w_any_idx, w_aged_idx, w_win;
    logic                  w_grant, w_slot_free, w_pop, w_last;

    function automatic logic [QW-1:0] rr_idx(input logic [QW-1:0] base, input int k);
        return base + QW'(k);
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_Q; i++) begin
            w_row[i]  = q_row[i*ROW_BITS +: ROW_BITS];
            w_data[i] = q_data[i*ENTRY_SIZE +: ENTRY_SIZE];
            w_cand[i] = !q_empty[i];
            w_hit[i]  = !q_empty[i] && r_open_row_vld && (q_row[i*ROW_BITS +: ROW_BITS] == r_open_row);
        end
    end

`ifdef BS_AGING_EN
    localparam int AW = $clog2(AGE_LIMIT + 1);
    logic [AW-1:0] r_age [NUM_Q];

    // Waiting only counts while another queue holds the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_Q; i++) r_age[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_Q; i++) begin
                if (w_grant && (w_win == QW'(i)))
                    r_age[i] <= '0;
                else if ((r_state == DRAIN) && !q_empty[i] && (r_gnt != QW'(i))
                         && (r_age[i] != AW'(AGE_LIMIT)))
                    r_age[i] <= r_age[i] + AW'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_Q; i++)
            w_aged[i] = !q_empty[i] && (r_age[i] == AW'(AGE_LIMIT));
    end
`else
    assign w_aged = '0;
`endif

    // Aged: lowest index. Row hit, then any: round-robin starting after rr_last.
    always_comb begin
        w_aged_found = 1'b0;
        w_aged_idx   = '0;
        w_hit_found  = 1'b0;
        w_hit_idx    = '0;
        w_any_found  = 1'b0;
        w_any_idx    = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            if (!w_aged_found && w_aged[i]) begin
                w_aged_found = 1'b1;
                w_aged_idx   = QW'(i);
            end
        end
        for (int k = 1; k <= NUM_Q; k++) begin
            if (!w_hit_found && w_hit[rr_idx(r_rr_last, k)]) begin
                w_hit_found = 1'b1;
                w_hit_idx   = rr_idx(r_rr_last, k);
            end
            if (!w_any_found && w_cand[rr_idx(r_rr_last, k)]) begin
                w_any_found = 1'b1;
                w_any_idx   = rr_idx(r_rr_last, k);
            end
        end
        w_win   = w_aged_found ? w_aged_idx : (w_hit_found ? w_hit_idx : w_any_idx);
        w_grant = (r_state == IDLE) && w_any_found;
    end

    assign w_slot_free = !r_out_valid || out_ready;
    assign w_pop  = (r_state == DRAIN) && w_slot_free && !q_empty[r_gnt]
                    && (r_burst_cnt < BMAX)
                    && ((r_burst_cnt == '0) || (w_row[r_gnt] == r_open_row));
    assign w_last = w_pop && ((r_burst_cnt + BW'(1)) == BMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        q_rd_en     = '0;
        case (r_state)
            IDLE:  if (w_grant) w_state_nxt = DRAIN;
            DRAIN: begin
                if (w_pop) q_rd_en[r_gnt] = 1'b1;
                // Burst ends on the cap, or when a free slot finds nothing to pop.
                if (w_last || (w_slot_free && !w_pop)) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt          <= '0;
            r_rr_last      <= QW'(NUM_Q - 1);
            r_burst_cnt    <= '0;
            r_open_row_vld <= 1'b0;
            r_open_row     <= '0;
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_out_qid      <= '0;
        end else begin
            if (w_grant) begin
                r_gnt       <= w_win;
                r_rr_last   <= w_win;
                r_burst_cnt <= '0;
            end
            if (w_pop) begin
                r_out_data     <= w_data[r_gnt];
                r_out_qid      <= r_gnt;
                r_out_valid    <= 1'b1;
                r_open_row     <= w_row[r_gnt];
                r_open_row_vld <= 1'b1;
                r_burst_cnt    <= r_burst_cnt + BW'(1);
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_qid   = r_out_qid;
    assign open_row  = r_open_row;
    assign busy      = (r_state == DRAIN) || r_out_valid;

endmodule

// File: doc/bs_burst_drainer.md
# bs_burst_drainer

Consumer side of the front-end request queues: watches the empty flag, head row and head entry of NUM_Q per-bank FIFO arrays, picks one queue, and pops a burst of same-row requests from it. Popped entries go onto a valid/ready stream toward the command scheduler. Arbitration prefers row hits against the last issued row, then falls back to round-robin.

## Interface
Parameters:
- NUM_Q, 4, number of queues drained; power of two, ≥2
- ENTRY_SIZE, 32, request entry width
- ROW_BITS, 4, width of each queue's head-row field
- BURST_MAX, 4, maximum pops per grant; ≥1
- AGE_LIMIT, 15, wait-cycle threshold; used only with BS_AGING_EN

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- q_empty  in  NUM_Q  per-queue empty flag
- q_row  in  NUM_Q*ROW_BITS  head-entry row of queue i at [i*ROW_BITS +: ROW_BITS]
- q_data  in  NUM_Q*ENTRY_SIZE  head entry of queue i at [i*ENTRY_SIZE +: ENTRY_SIZE]
- q_rd_en  out  NUM_Q  one-hot-or-zero pop strobe; one pulse pops one entry
- out_valid  out  1  out_data holds a request
- out_ready  in  1  downstream accepts on out_valid && out_ready
- out_data  out  ENTRY_SIZE  registered request
- out_qid  out  $clog2(NUM_Q)  source queue of out_data
- open_row  out  ROW_BITS  row of the most recently popped entry
- busy  out  1  (state==DRAIN) || out_valid

## Operation
- There are two states: IDLE and DRAIN. Internal registers:
  - gnt: $clog2(NUM_Q) bits
  - burst_cnt: $clog2(BURST_MAX+1) bits
  - rr_last
  - open_row_vld
- IDLE arbitration (evaluated every cycle; the decision registers at the edge):
  - Candidates are the queues with q_empty[i]==0. If there are none, stay in IDLE.
  - With BS_AGING_EN, the lowest-index aged candidate wins first.
  - Otherwise, the winner is a row-hit candidate (open_row_vld && q_row[i]==open_row), searched round-robin from rr_last+1.
  - If there is no row hit, the winner is any candidate, round-robin from rr_last+1.
  - On a win: gnt<=winner, rr_last<=winner, burst_cnt<=0, go to DRAIN.
- In DRAIN, slot_free = !out_valid || out_ready. q_rd_en[gnt] is asserted combinationally in the same cycle when all of the following hold:
  - slot_free
  - !q_empty[gnt]
  - burst_cnt<BURST_MAX
  - burst_cnt==0 || q_row[gnt]==open_row
- Effects of a pop:
  - out_data<=q_data[gnt]
  - out_qid<=gnt
  - out_valid<=1
  - open_row<=q_row[gnt]
  - open_row_vld<=1
  - burst_cnt++
- DRAIN exits to IDLE in either case:
  - The pop that makes burst_cnt==BURST_MAX.
  - A slot_free cycle in which the pop condition fails (queue empty or row miss).
- A stalled output (out_valid && !out_ready) holds DRAIN: no pop, and out_data/out_qid stay stable.
- out_valid clears on acceptance when no pop occurs in the same cycle. An accept and a pop in the same cycle keep out_valid=1 with the new data.
- q_rd_en is never asserted in IDLE.
- Reset values: state IDLE, q_rd_en 0, out_valid 0, out_data 0, out_qid 0, open_row 0, open_row_vld 0, busy 0, burst_cnt 0, gnt 0, rr_last NUM_Q-1 (so the first round-robin pick is queue 0), age counters 0.
- Reset mid-burst clears everything immediately. The entry held in out_data is dropped, and q_rd_en drops the instant rst_n falls.

## Timing
- A queue going non-empty in IDLE during cycle N gets its grant at the end of N.
- q_rd_en pulses in cycle N+1; out_valid rises in N+2.
- Back-to-back pops within a burst: one per cycle while out_ready=1.
- Burst end to next grant: one IDLE cycle minimum. The IDLE cycle overlaps the draining of the last out_data.
- The q_* inputs are sampled combinationally; the queue must present its new head one cycle after a pop.

## Configuration
- BS_AGING_EN defined:
  - Each queue has a saturating counter of $clog2(AGE_LIMIT+1) bits.
  - The counter increments each cycle the queue is non-empty and is not gnt while in DRAIN, and clears when the queue is granted.
  - A queue whose counter equals AGE_LIMIT is "aged" and preempts row-hit priority in IDLE.
- BS_AGING_EN undefined: no counters; arbitration is pure row-hit then round-robin.

## Test plan
- Reset: assert rst_n low during DRAIN with out_valid=1 → out_valid=0, q_rd_en=0, busy=0 immediately, open_row=0.
- Simple burst: queue 0 holds entries A,B,C all row 5, out_ready=1 → q_rd_en=4'b0001 for 3 consecutive cycles starting N+1, out_data A,B,C in N+2..N+4, then IDLE, open_row=5.
- Row-hit priority: open_row=5 with rr_last=0; queue 1 head row 7, queue 2 head row 5 → gnt=2, out_qid=2.
- Burst cap: BURST_MAX=4, queue 0 holds 6 entries of row 3, all others empty → 4 pops, one IDLE cycle, regrant of queue 0, 2 more pops.
- Backpressure: out_ready=0 for 3 cycles mid-burst → out_data stable, q_rd_en=0, no entry lost or duplicated once out_ready=1.
- Aging (BS_AGING_EN, AGE_LIMIT=15): queue 0 refills row 5 continuously; queue 3 waits with head row 9 → queue 3 is granted at the first IDLE after its counter reaches 15, and its counter clears.
